// File: rtl/nand_target_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nand_target_responder
// Brief    : Device end of a NAND pin interface. Oversamples the NAND strobes
//            on HCLK, decodes command/address/data latch cycles and serves
//            read, program, status, ID and reset from an external page buffer
//            and an external array-operation handshake.
// Options  : define NAND_TGT_FAULT_INJ_EN to XOR page read data with fault_xor
// Revision : 1.0 - initial release
// ============================================================================
module nand_target_responder #(
  parameter int          PAGE_BYTES = 2112,
  parameter int          BUSY_EXTRA = 8,
  parameter int          RST_BUSY   = 16,
  parameter logic [31:0] ID_WORD    = 32'hC2F1801D
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        CE_n,
  input  logic        CLE,
  input  logic        ALE,
  input  logic        WE_n,
  input  logic        RE_n,
  input  logic [7:0]  dio_in,
  output logic [7:0]  dio_out,
  output logic        dio_oe,
  output logic        R_nB,
  output logic [11:0] buf_addr,
  output logic [7:0]  buf_wdata,
  output logic        buf_we,
  input  logic [7:0]  buf_rdata,
  output logic [15:0] arr_row,
  output logic        arr_load,
  output logic        arr_prog,
  input  logic        arr_done,
  input  logic        arr_fail,
  input  logic [7:0]  fault_xor
);

  localparam logic [11:0] COL_LAST = 12'(PAGE_BYTES - 1);
  localparam int          CNT_W    = $clog2(BUSY_EXTRA + RST_BUSY + 1);
  // Pin vector order {CE_n, CLE, ALE, WE_n, RE_n}; idle = deselected, strobes high
  localparam logic [4:0]  PIN_IDLE = 5'b10011;

  localparam logic [7:0] CMD_READ     = 8'h00;
  localparam logic [7:0] CMD_READ_CFM = 8'h30;
  localparam logic [7:0] CMD_PROG     = 8'h80;
  localparam logic [7:0] CMD_PROG_CFM = 8'h10;
  localparam logic [7:0] CMD_STATUS   = 8'h70;
  localparam logic [7:0] CMD_ID       = 8'h90;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DIN, S_WAIT_CFM, S_BUSY, S_DOUT, S_STATUS, S_ID
  } state_t;
  typedef enum logic [1:0] {K_READ, K_PROG, K_ID} kind_t;    // command that opened ADDR
  typedef enum logic [1:0] {OP_LOAD, OP_PROG, OP_RST} op_t;  // what the busy period is for

  logic [4:0] sync1_q, sync2_q;
  logic [1:0] strb_prev_q;                       // {WE_n, RE_n} one cycle behind sync2
  logic       ce_n_s, cle_s, ale_s, we_rise, re_fall, re_rise;

  state_t       state_q, state_d, prev_q, prev_d, eff, done_tgt;
  kind_t        kind_q, kind_d;
  op_t          op_q, op_d;
  logic [1:0]   addr_cnt_q, addr_cnt_d, id_idx_q, id_idx_d;
  logic [11:0]  col_q, col_d, col_next, col_cand;
  logic [15:0]  row_q, row_d;
  logic         fail_q, fail_d, busy_q, busy_d, cnt_run_q, cnt_run_d, done_now;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic         rnb_q, rnb_d, dio_oe_q, dio_oe_d, buf_we_q, buf_we_d;
  logic         arr_load_q, arr_load_d, arr_prog_q, arr_prog_d;
  logic [7:0]   dio_out_q, dio_out_d, buf_wdata_q, buf_wdata_d;
  logic [11:0]  buf_addr_q, buf_addr_d;
  logic [7:0]   rd_byte, status_byte, id_byte;

  assign ce_n_s  = sync2_q[4];
  assign cle_s   = sync2_q[3];
  assign ale_s   = sync2_q[2];
  assign we_rise =  sync2_q[1] & ~strb_prev_q[1];
  assign re_fall = ~sync2_q[0] &  strb_prev_q[0];
  assign re_rise =  sync2_q[0] & ~strb_prev_q[0];

  assign col_next    = (col_q == COL_LAST) ? 12'd0 : col_q + 12'd1;
  assign col_cand    = {dio_in[3:0], col_q[7:0]};
  assign status_byte = {1'b1, rnb_q, rnb_q, 4'b0000, fail_q};
  assign id_byte     = ID_WORD[{~id_idx_q, 3'b000} +: 8];

`ifdef NAND_TGT_FAULT_INJ_EN
  assign rd_byte = buf_rdata ^ fault_xor;
`else
  logic unused_fault_xor;
  assign unused_fault_xor = ^fault_xor;
  assign rd_byte = buf_rdata;
`endif

  // Two-flop synchronizers plus one extra stage on the strobes for edge detection
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sync1_q     <= PIN_IDLE;
      sync2_q     <= PIN_IDLE;
      strb_prev_q <= 2'b11;
    end else begin
      sync1_q     <= {CE_n, CLE, ALE, WE_n, RE_n};
      sync2_q     <= sync1_q;
      strb_prev_q <= sync2_q[1:0];
    end
  end

  // Next-state: busy engine first, then CE_n deselect, then latch and read strobes
  always_comb begin
    state_d = state_q;   prev_d = prev_q;     kind_d = kind_q;     op_d = op_q;
    addr_cnt_d = addr_cnt_q; id_idx_d = id_idx_q; col_d = col_q;   row_d = row_q;
    fail_d = fail_q;     busy_d = busy_q;     cnt_run_d = cnt_run_q; cnt_d = cnt_q;
    dio_oe_d = dio_oe_q; buf_we_d = 1'b0;     buf_wdata_d = buf_wdata_q;
    buf_addr_d = col_q;  arr_load_d = 1'b0;   arr_prog_d = 1'b0;
    done_tgt = (op_q == OP_LOAD) ? S_DOUT : S_IDLE;
    done_now = busy_q & cnt_run_q & (cnt_q == '0);

    if (busy_q) begin
      if (done_now) begin
        busy_d = 1'b0;
        cnt_run_d = 1'b0;
        if (state_q == S_BUSY)        state_d = done_tgt;
        else if (state_q == S_STATUS) prev_d  = done_tgt;
      end else if (cnt_run_q) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else if (arr_done) begin
        fail_d    = arr_fail;
        cnt_run_d = 1'b1;
        cnt_d     = CNT_W'(BUSY_EXTRA - 1);
      end
    end

    // A status read resumes whatever state it interrupted
    eff = (state_d == S_STATUS) ? prev_d : state_d;

    if (ce_n_s) begin
      dio_oe_d = 1'b0;
      if (state_d == S_STATUS)    state_d = (prev_d == S_BUSY) ? S_BUSY : S_IDLE;
      else if (state_d != S_BUSY) state_d = S_IDLE;
    end else begin
      if (we_rise && cle_s && !ale_s) begin
        if (dio_in == CMD_RESET) begin
          state_d = S_BUSY;  busy_d = 1'b1;  cnt_run_d = 1'b1;
          cnt_d = CNT_W'(RST_BUSY);  op_d = OP_RST;  dio_oe_d = 1'b0;
        end else if (dio_in == CMD_STATUS) begin
          if (state_d != S_STATUS) prev_d = state_d;
          state_d = S_STATUS;
        end else if (eff == S_BUSY) begin
          state_d = S_BUSY;
        end else if (eff == S_WAIT_CFM) begin
          state_d = S_IDLE;
          if (dio_in == CMD_READ_CFM) begin
            arr_load_d = 1'b1;  busy_d = 1'b1;  cnt_run_d = 1'b0;
            op_d = OP_LOAD;     state_d = S_BUSY;
          end
        end else if (eff == S_DIN) begin
          state_d = S_IDLE;
          if (dio_in == CMD_PROG_CFM) begin
            arr_prog_d = 1'b1;  busy_d = 1'b1;  cnt_run_d = 1'b0;
            op_d = OP_PROG;     state_d = S_BUSY;
          end
        end else begin
          addr_cnt_d = 2'd0;
          state_d    = S_ADDR;
          case (dio_in)
            CMD_READ: kind_d = K_READ;
            CMD_PROG: begin kind_d = K_PROG; fail_d = 1'b0; end
            CMD_ID:   kind_d = K_ID;
            default:  state_d = S_IDLE;
          endcase
        end
      end else if (we_rise && ale_s && !cle_s && state_d == S_ADDR) begin
        addr_cnt_d = addr_cnt_q + 2'd1;
        if (kind_q == K_ID) begin
          id_idx_d = 2'd0;
          state_d  = (dio_in == 8'h00) ? S_ID : S_IDLE;
        end else begin
          case (addr_cnt_q)
            2'd0:    col_d = {col_q[11:8], dio_in};
            2'd1:    col_d = (col_cand > COL_LAST) ? 12'd0 : col_cand;
            2'd2:    row_d = {row_q[15:8], dio_in};
            default: begin
              row_d   = {dio_in, row_q[7:0]};
              state_d = (kind_q == K_PROG) ? S_DIN : S_WAIT_CFM;
            end
          endcase
        end
      end else if (we_rise && !ale_s && !cle_s && state_d == S_DIN) begin
        buf_we_d    = 1'b1;
        buf_wdata_d = dio_in;
        col_d       = col_next;
      end

      if (re_fall && (state_d == S_DOUT || state_d == S_STATUS || state_d == S_ID))
        dio_oe_d = 1'b1;
      if (re_rise) begin
        dio_oe_d = 1'b0;
        if (state_d == S_DOUT)    col_d    = col_next;
        else if (state_d == S_ID) id_idx_d = id_idx_q + 2'd1;
      end
    end

    // R_nB drops the cycle after the busy period starts and rises as it ends
    rnb_d = ~(busy_q & busy_d);

    dio_out_d = dio_out_q;
    case (state_q)
      S_DOUT:   dio_out_d = rd_byte;
      S_STATUS: dio_out_d = status_byte;
      S_ID:     dio_out_d = id_byte;
      default:  dio_out_d = dio_out_q;
    endcase
  end

  // Control and datapath registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;  prev_q <= S_IDLE;  kind_q <= K_READ;  op_q <= OP_LOAD;
      addr_cnt_q <= 2'd0; id_idx_q <= 2'd0;  col_q <= 12'd0;    row_q <= 16'd0;
      fail_q <= 1'b0;     busy_q <= 1'b0;    cnt_run_q <= 1'b0; cnt_q <= '0;
      rnb_q <= 1'b1;      dio_oe_q <= 1'b0;  dio_out_q <= 8'h00;
      buf_we_q <= 1'b0;   buf_wdata_q <= 8'h00; buf_addr_q <= 12'd0;
      arr_load_q <= 1'b0; arr_prog_q <= 1'b0;
    end else begin
      state_q <= state_d;  prev_q <= prev_d;  kind_q <= kind_d;  op_q <= op_d;
      addr_cnt_q <= addr_cnt_d; id_idx_q <= id_idx_d; col_q <= col_d; row_q <= row_d;
      fail_q <= fail_d;    busy_q <= busy_d;  cnt_run_q <= cnt_run_d; cnt_q <= cnt_d;
      rnb_q <= rnb_d;      dio_oe_q <= dio_oe_d; dio_out_q <= dio_out_d;
      buf_we_q <= buf_we_d; buf_wdata_q <= buf_wdata_d; buf_addr_q <= buf_addr_d;
      arr_load_q <= arr_load_d; arr_prog_q <= arr_prog_d;
    end
  end

  assign dio_out   = dio_out_q;
  assign dio_oe    = dio_oe_q;
  assign R_nB      = rnb_q;
  assign buf_addr  = buf_addr_q;
  assign buf_wdata = buf_wdata_q;
  assign buf_we    = buf_we_q;
  assign arr_row   = row_q;
  assign arr_load  = arr_load_q;
  assign arr_prog  = arr_prog_q;

endmodule
`default_nettype wire

// File: doc/nand_target_responder.md
Name: nand_target_responder

Overview:
- Synthesizable NAND flash target: the device end of the controller's NAND pin interface (DIO, WE_n, RE_n, CE_n, CLE, ALE, R_nB).
- Oversamples the asynchronous NAND strobes on HCLK and decodes command, address and data latch cycles.
- Serves read, program, status, ID and reset commands from an external page buffer RAM and an external array-operation handshake.
- Replaces the behavioural flash model for FPGA prototyping and emulation of the controller.

Parameters:
- PAGE_BYTES, 2112: bytes per page including spare; the column counter wraps at this value.
- BUSY_EXTRA, 8: HCLK cycles R_nB stays low after arr_done.
- RST_BUSY, 16: HCLK cycles R_nB stays low after command FFh.
- ID_WORD, 32'hC2F1801D: Read ID bytes, most significant byte first.

Ports:
- HCLK  in  1  single clock.
- HRESET  in  1  synchronous, active-high reset.
- CE_n  in  1  chip enable, active low.
- CLE  in  1  command latch enable.
- ALE  in  1  address latch enable.
- WE_n  in  1  write strobe; data is latched on its rising edge.
- RE_n  in  1  read strobe.
- dio_in  in  8  DIO input path.
- dio_out  out  8  DIO output path.
- dio_oe  out  1  DIO output enable.
- R_nB  out  1  ready (1) / busy (0).
- buf_addr  out  12  page buffer byte address.
- buf_wdata  out  8  page buffer write data.
- buf_we  out  1  page buffer write strobe.
- buf_rdata  in  8  page buffer read data, 1-cycle read latency.
- arr_row  out  16  row address for the array operation.
- arr_load  out  1  1-cycle pulse: load page array -> buffer.
- arr_prog  out  1  1-cycle pulse: program buffer -> array.
- arr_done  in  1  1-cycle pulse: array operation complete.
- arr_fail  in  1  program failed; sampled together with arr_done.
- fault_xor  in  8  read-data corruption mask (used only with the optional feature).

Behaviour:
- Strobe sampling:
  - CE_n, CLE, ALE, WE_n, RE_n each pass through a 2-flop synchronizer, then edge detection.
  - A pin edge is acted on 3 HCLK cycles later.
  - dio_in is sampled at the detected WE_n rise. Controller setup/hold therefore require WE_n high and low phases of at least 4 HCLK each.
- Latch cycles, on WE_n rise with CE_n low:
  - CLE=1, ALE=0: command cycle.
  - ALE=1, CLE=0: address cycle.
  - CLE=0, ALE=0: data-in cycle.
  - CLE=1 and ALE=1 together: cycle ignored.
- Address cycles: 4 bytes, in order col[7:0], col[11:8], row[7:0], row[15:8].
  - Extra address cycles are ignored.
  - A latched column >= PAGE_BYTES is replaced by 0.
- States: IDLE, ADDR, DIN, WAIT_CFM, BUSY, DOUT, STATUS, ID.
  - 00h: ADDR. After the 4th address byte -> WAIT_CFM.
  - 30h in WAIT_CFM: pulse arr_load with arr_row -> BUSY.
  - 80h: ADDR. After the 4th address byte -> DIN.
  - In DIN, each data cycle writes buf_wdata at buf_addr=col with buf_we for one cycle, then col increments.
  - 10h in DIN: pulse arr_prog -> BUSY.
  - 70h from any state: STATUS. A following RE_n cycle returns the status byte; the previous state resumes on the next command.
  - 90h then address 00h: ID.
  - FFh from any state: abort the current operation, R_nB=0 for RST_BUSY cycles, then IDLE.
  - An unknown command, or a wrong confirm byte (anything other than 30h/10h in WAIT_CFM/DIN), returns to IDLE.
- BUSY state:
  - R_nB=0 from the cycle after the pulse.
  - After arr_done, R_nB returns to 1 BUSY_EXTRA cycles later.
  - Then load completes -> DOUT with col preserved; program completes -> IDLE.
  - Commands other than 70h and FFh are ignored while busy.
- Read data path:
  - On detected RE_n fall, dio_oe=1 and dio_out is presented 2 cycles later (buf_rdata latency plus output register).
  - On detected RE_n rise, col increments.
  - col wraps from PAGE_BYTES-1 to 0.
  - dio_oe deasserts on RE_n rise or CE_n high.
- Status byte: {1'b1, rdy, rdy, 4'b0, fail}.
  - Ready with no fail = 8'hE0; busy = 8'h80.
  - fail is latched from arr_fail at arr_done and cleared by the next 80h.
- ID bytes: ID_WORD, MSB first; wraps to byte 0 after the 4th.
- CE_n high: dio_oe=0 and the FSM returns to IDLE, except in BUSY, which runs to completion.
- Reset values: dio_oe=0, dio_out=8'h00, R_nB=1, buf_we=0, buf_addr=0, buf_wdata=0, arr_load=0, arr_prog=0, arr_row=0, status fail=0, state IDLE.
- HRESET mid-operation: an in-flight arr_done is ignored and R_nB=1 on the next cycle.

Optional Feature:
- Macro: NAND_TGT_FAULT_INJ_EN.
- When defined: dio_out is XORed with fault_xor in the DOUT state only; status and ID bytes are not affected.
- When undefined: fault_xor is ignored and no XOR logic is built.

Test Plan:
- Read ID: 90h, addr 00h, 5 RE_n pulses -> C2, F1, 80, 1D, C2.
- Page read: 00h, addr 10,00,A0,0F, 30h; buffer[0x010]=5A, [0x011]=3C -> arr_load pulse with arr_row=0x0FA0; R_nB low until arr_done+8 cycles; reads return 5A then 3C.
- Program: 80h, addr 00,00,01,00, data 11,22, 10h, arr_done with arr_fail=1 -> buffer[0]=11, [1]=22; arr_prog with row 0x0001; 70h then RE_n returns E1.
- Column wrap: read starting at col 2111 with 2 RE_n -> buf_addr 2111 then 0.
- FFh mid-DIN: data cycles stop; R_nB low 16 cycles; next 70h returns E0.
- HRESET during BUSY -> R_nB=1 next cycle; a subsequent arr_done is ignored and the state stays IDLE.
